// File: rtl/serial_alu.sv
// Digit-serial ALU: operands are consumed LSB-first, DIGIT bits per cycle, over WIDTH/DIGIT cycles.
// Result and Z/C/N/V flags are published together on the RUN->DONE edge and held until taken.
module serial_alu #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
                           OP_XOR = 3'b100, OP_ADC = 3'b101, OP_SBC = 3'b110, OP_PSB = 3'b111;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic             carry_q, carry_d, nz_q, nz_d;
    logic [3:0]       flags_q, flags_d;

    logic             is_sub, is_arith;
    logic [DIGIT-1:0] dig;
    logic             cc, bi, c_msb;
    logic [WIDTH-1:0] sh_next;

    assign is_sub   = (op_q == OP_SUB) || (op_q == OP_SBC);
    assign is_arith = is_sub || (op_q == OP_ADD) || (op_q == OP_ADC);

    // One digit of work: ripple across DIGIT bits starting from the registered carry.
    always_comb begin
        cc    = carry_q;
        c_msb = carry_q;
        bi    = 1'b0;
        dig   = '0;
        for (int i = 0; i < DIGIT; i++) begin
            bi    = b_q[i] ^ is_sub;
            c_msb = cc;
            unique case (op_q)
                OP_AND:  dig[i] = a_q[i] & b_q[i];
                OP_OR:   dig[i] = a_q[i] | b_q[i];
                OP_XOR:  dig[i] = a_q[i] ^ b_q[i];
                OP_PSB:  dig[i] = b_q[i];
                default: dig[i] = a_q[i] ^ bi ^ cc;
            endcase
            cc = (a_q[i] & bi) | (a_q[i] & cc) | (bi & cc);
        end
        sh_next = (sh_q >> DIGIT) | (WIDTH'(dig) << (WIDTH - DIGIT));
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        sh_d     = sh_q;
        op_d     = op_q;
        carry_d  = carry_q;
        nz_d     = nz_q;
        result_d = result_q;
        flags_d  = flags_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (in_valid) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    cnt_d   = '0;
                    nz_d    = 1'b0;
                    unique case (op)
                        OP_SUB:         carry_d = 1'b1;
                        OP_ADC, OP_SBC: carry_d = carry_in;
                        default:        carry_d = 1'b0;
                    endcase
                end
                RUN: begin
                    a_d     = a_q >> DIGIT;
                    b_d     = b_q >> DIGIT;
                    sh_d    = sh_next;
                    carry_d = cc;
                    nz_d    = nz_q | (|dig);
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d  = DONE;
                        cnt_d    = '0;
                        result_d = sh_next;
                        flags_d  = {~(nz_q | (|dig)), is_arith & cc, sh_next[WIDTH-1],
                                    is_arith & (cc ^ c_msb)};
                    end
                end
                DONE: if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sh_q     <= '0;
            op_q     <= OP_ADD;
            carry_q  <= 1'b0;
            nz_q     <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sh_q     <= sh_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            nz_q     <= nz_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign flags     = flags_q;
endmodule

// File: tb/tb_serial_alu.sv
// Bench for serial_alu: three instances (16/1, 16/4, 8/8) behind one selectable stimulus port,
// directed vector table, handshake/flush/reset sequences, and random ops against an arithmetic model.
module tb_serial_alu;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, carry_in = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [15:0] a = '0, b = '0;
    int          sel = 0;

    logic        rdy0, rdy1, rdy2, ov0, ov1, ov2;
    logic [15:0] res0, res1;
    logic [7:0]  res2;
    logic [3:0]  flg0, flg1, flg2;

    serial_alu #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 0), .in_ready(rdy0), .op(op),
        .a(a), .b(b), .carry_in(carry_in), .flush(flush && sel == 0), .out_valid(ov0),
        .out_ready(out_ready && sel == 0), .result(res0), .flags(flg0));
    serial_alu #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 1), .in_ready(rdy1), .op(op),
        .a(a), .b(b), .carry_in(carry_in), .flush(flush && sel == 1), .out_valid(ov1),
        .out_ready(out_ready && sel == 1), .result(res1), .flags(flg1));
    serial_alu #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 2), .in_ready(rdy2), .op(op),
        .a(a[7:0]), .b(b[7:0]), .carry_in(carry_in), .flush(flush && sel == 2), .out_valid(ov2),
        .out_ready(out_ready && sel == 2), .result(res2), .flags(flg2));

    logic        cur_rdy, cur_ov;
    logic [15:0] cur_res;
    logic [3:0]  cur_flg;
    always_comb begin
        cur_rdy = rdy0; cur_ov = ov0; cur_res = res0; cur_flg = flg0;
        if (sel == 1) begin
            cur_rdy = rdy1; cur_ov = ov1; cur_res = res1; cur_flg = flg1;
        end else if (sel == 2) begin
            cur_rdy = rdy2; cur_ov = ov2; cur_res = {8'h00, res2}; cur_flg = flg2;
        end
    end

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic int width_of(input int s);
        return (s == 2) ? 8 : 16;
    endfunction

    function automatic int lat_of(input int s);
        return (s == 0) ? 16 : (s == 1) ? 4 : 1;
    endfunction

    // Reference: whole-word integer arithmetic; V from the true signed sum falling out of range.
    function automatic void model(input int w, input logic [2:0] o, input logic [15:0] x, y,
                                  input logic ci, output logic [15:0] r, output logic [3:0] f);
        longint mask, half, ua, ub, s, sa, sb, ssum;
        logic c, v, arith;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua = longint'(x) & mask;
        ub = longint'(y) & mask;
        sa = (ua >= half) ? ua - (mask + 1) : ua;
        sb = (ub >= half) ? ub - (mask + 1) : ub;
        arith = 1'b1;
        s = 0; ssum = 0;
        case (o)
            3'd0: begin s = ua + ub;                       ssum = sa + sb;                end
            3'd5: begin s = ua + ub + ci;                  ssum = sa + sb + ci;           end
            3'd1: begin s = ua + ((~ub) & mask) + 1;       ssum = sa - sb;                end
            3'd6: begin s = ua + ((~ub) & mask) + ci;      ssum = sa - sb - 1 + ci;       end
            3'd2: begin s = ua & ub; arith = 1'b0; end
            3'd3: begin s = ua | ub; arith = 1'b0; end
            3'd4: begin s = ua ^ ub; arith = 1'b0; end
            default: begin s = ub;   arith = 1'b0; end
        endcase
        c = arith && ((s >> w) & 1) != 0;
        v = arith && (ssum >= half || ssum < -half);
        r = 16'(s & mask);
        f = {(r == 16'h0), c, r[w-1], v};
    endfunction

    task automatic do_op(input int s, input logic [2:0] o, input logic [15:0] x, y, input logic ci,
                         output logic [15:0] r, output logic [3:0] f, output int lat);
        sel = s;
        @(negedge clk);
        in_valid = 1'b1; op = o; a = x; b = y; carry_in = ci;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!cur_ov && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        r = cur_res;
        f = cur_flg;
    endtask

    task automatic finish_op;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    typedef struct {
        int          s;
        logic [2:0]  o;
        logic [15:0] x, y;
        logic        ci;
        logic [15:0] er;
        logic [3:0]  ef;
        int          lat;
    } vec_t;
    vec_t vq[$];

    initial begin
        logic [15:0] r, er, keep_r;
        logic [3:0]  f, ef, keep_f;
        int          lat, seen;
        logic [2:0]  ro;
        logic [15:0] rx, ry;
        logic        rc;
        int          rs;

        vq.push_back('{0, 3'd0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 4'b0000, 16});
        vq.push_back('{0, 3'd1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 4'b0010, 16});
        vq.push_back('{0, 3'd1, 16'h0007, 16'h0007, 1'b0, 16'h0000, 4'b1100, 16});
        vq.push_back('{0, 3'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b0011, 16});
        vq.push_back('{0, 3'd5, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 4'b1100, 16});
        vq.push_back('{0, 3'd3, 16'h8000, 16'h0001, 1'b0, 16'h8001, 4'b0010, 16});
        vq.push_back('{1, 3'd4, 16'hA5A5, 16'hFFFF, 1'b0, 16'h5A5A, 4'b0000, 4});
        vq.push_back('{1, 3'd6, 16'h0010, 16'h0001, 1'b0, 16'h000E, 4'b0100, 4});
        vq.push_back('{1, 3'd2, 16'hF0F0, 16'h0F0F, 1'b1, 16'h0000, 4'b1000, 4});
        vq.push_back('{1, 3'd1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b0101, 4});
        vq.push_back('{2, 3'd0, 16'h007F, 16'h0001, 1'b0, 16'h0080, 4'b0011, 1});
        vq.push_back('{2, 3'd7, 16'h0012, 16'h00F0, 1'b1, 16'h00F0, 4'b0010, 1});

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_in_ready", {29'd0, rdy2, rdy1, rdy0}, 32'h7);
        chk("reset_out_valid", {29'd0, ov2, ov1, ov0}, 32'h0);
        chk("reset_result", {16'd0, res0}, 32'h0);
        chk("reset_flags", {28'd0, flg0}, 32'h0);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            do_op(vq[i].s, vq[i].o, vq[i].x, vq[i].y, vq[i].ci, r, f, lat);
            chk($sformatf("vec%0d_result", i), {16'd0, r}, {16'd0, vq[i].er});
            chk($sformatf("vec%0d_flags", i), {28'd0, f}, {28'd0, vq[i].ef});
            chk($sformatf("vec%0d_latency", i), lat, vq[i].lat);
            finish_op();
        end

        // Back-pressure in DONE: outputs hold, in_valid pulses ignored, no same-cycle re-accept
        do_op(0, 3'd1, 16'h0005, 16'h0007, 1'b0, keep_r, keep_f, lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0] ? 1'b0 : 1'b1;
            a = 16'($urandom);
            @(negedge clk);
            chk("hold_result", {16'd0, cur_res}, {16'd0, keep_r});
            chk("hold_flags", {28'd0, cur_flg}, {28'd0, keep_f});
            chk("hold_in_ready", {31'd0, cur_rdy}, 32'd0);
            chk("hold_out_valid", {31'd0, cur_ov}, 32'd1);
        end
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        chk("release_in_ready", {31'd0, cur_rdy}, 32'd1);
        chk("release_out_valid", {31'd0, cur_ov}, 32'd0);
        @(negedge clk);
        chk("no_reaccept", {31'd0, cur_rdy}, 32'd1);

        // Flush at RUN cycle 7, then flush beating an accept in IDLE
        sel = 0;
        @(negedge clk);
        in_valid = 1'b1; op = 3'd0; a = 16'h1111; b = 16'h2222; carry_in = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_in_ready", {31'd0, cur_rdy}, 32'd1);
        chk("flush_keeps_result", {16'd0, cur_res}, {16'd0, keep_r});
        chk("flush_keeps_flags", {28'd0, cur_flg}, {28'd0, keep_f});
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cur_ov) seen++;
        end
        chk("flush_no_out_valid", seen, 0);
        in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_beats_accept", {31'd0, cur_rdy}, 32'd1);

        // Async reset mid-RUN
        @(negedge clk);
        in_valid = 1'b1; op = 3'd0; a = 16'h4321; b = 16'h0101;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_in_ready", {31'd0, rdy0}, 32'd1);
        chk("rst_mid_out_valid", {31'd0, ov0}, 32'd0);
        chk("rst_mid_result", {16'd0, res0}, 32'd0);
        chk("rst_mid_flags", {28'd0, flg0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 3'd0, 16'h1234, 16'h0FFF, 1'b0, r, f, lat);
        chk("post_rst_result", {16'd0, r}, 32'h2233);
        chk("post_rst_latency", lat, 16);
        finish_op();

        // Random ops against the arithmetic model
        for (int n = 0; n < 60; n++) begin
            rs = $urandom_range(0, 2);
            ro = 3'($urandom_range(0, 7));
            rx = 16'($urandom);
            ry = 16'($urandom);
            rc = 1'($urandom);
            model(width_of(rs), ro, rx, ry, rc, er, ef);
            do_op(rs, ro, rx, ry, rc, r, f, lat);
            chk($sformatf("rnd%0d_s%0d_op%0d_result", n, rs, ro), {16'd0, r}, {16'd0, er});
            chk($sformatf("rnd%0d_s%0d_op%0d_flags", n, rs, ro), {28'd0, f}, {28'd0, ef});
            chk($sformatf("rnd%0d_latency", n), lat, lat_of(rs));
            finish_op();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
